// File: rtl/fan_pkg.sv
// Shared definitions for the fan duty sequencer slice.
//   stage_e     : stage encoding used by both manual and auto stage sources
//   fsm_e       : duty sequencer states
//   timer_units : off-timer selection -> number of timer units {0,1,3,5}
package fan_pkg;

  typedef enum logic [1:0] {
    STAGE_STOP = 2'd0,
    STAGE_LOW  = 2'd1,
    STAGE_HIGH = 2'd2,
    STAGE_MAX  = 2'd3
  } stage_e;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'd0,
    FSM_KICK = 2'd1,
    FSM_RAMP = 2'd2,
    FSM_HOLD = 2'd3
  } fsm_e;

  function automatic logic [2:0] timer_units(input logic [1:0] sel);
    case (sel)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd5;
    endcase
  endfunction

endpackage

// File: rtl/fan_ms_divider.sv
// Modulo counter with enable and synchronous clear.
//   clk, reset_p : clock, asynchronous active-high reset
//   en_i         : count enable (counter holds when low)
//   clr_i        : synchronous clear, has priority over en_i
//   last_i       : terminal count (modulus - 1)
//   wrap_o       : high in the enabled clock where the counter is at last_i
module fan_ms_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_p,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] last_i,
  output logic             wrap_o
);

  logic [WIDTH-1:0] cnt_q;

  assign wrap_o = en_i && (cnt_q == last_i);

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= wrap_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/fan_duty_sequencer.sv
// Fan PWM duty sequencer: stage select, kick-start, rate-limited ramp, off-timer.
//   clk, reset_p : clock, asynchronous active-high reset
//   auto_onoff   : 1 selects stage_auto, 0 selects stage_man
//   stage_man    : manual stage (STOP/LOW/HIGH/MAX)
//   stage_auto   : auto stage, same encoding
//   timer_btn    : one-clock pulse, advances off-timer selection
//   duty         : PWM duty command 0..DUTY_MAX
//   state        : 1 while running (duty != 0 or kicking)
//   ramping      : 1 while in KICK or RAMP
//   timer_sel    : off-timer selection 0=off,1,2,3
//   timer_left   : timer units remaining
//   timeout      : one-clock pulse on off-timer expiry
module fan_duty_sequencer
  import fan_pkg::*;
#(
  parameter int unsigned CLK_HZ        = 100_000_000,
  parameter int unsigned DUTY_LOW      = 33,
  parameter int unsigned DUTY_HIGH     = 66,
  parameter int unsigned DUTY_MAX      = 99,
  parameter int unsigned DUTY_STEP     = 3,
  parameter int unsigned RAMP_MS       = 20,
  parameter int unsigned KICK_MS       = 200,
  parameter int unsigned TIMER_UNIT_MS = 3_600_000
) (
  input  logic       clk,
  input  logic       reset_p,
  input  logic       auto_onoff,
  input  logic [1:0] stage_man,
  input  logic [1:0] stage_auto,
  input  logic       timer_btn,
  output logic [7:0] duty,
  output logic       state,
  output logic       ramping,
  output logic [1:0] timer_sel,
  output logic [2:0] timer_left,
  output logic       timeout
);

  localparam int unsigned PRE_DIV = CLK_HZ / 1000;
  localparam int unsigned PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
  localparam int unsigned PH_MAX  = (KICK_MS > RAMP_MS) ? KICK_MS : RAMP_MS;
  localparam int unsigned PH_W    = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned UNIT_W  = (TIMER_UNIT_MS > 1) ? $clog2(TIMER_UNIT_MS) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRE_DIV - 1);
  localparam logic [PH_W-1:0]   KICK_LAST = PH_W'(KICK_MS - 1);
  localparam logic [PH_W-1:0]   RAMP_LAST = PH_W'(RAMP_MS - 1);
  localparam logic [UNIT_W-1:0] UNIT_LAST = UNIT_W'(TIMER_UNIT_MS - 1);

  localparam logic [7:0] D_LOW  = 8'(DUTY_LOW);
  localparam logic [7:0] D_HIGH = 8'(DUTY_HIGH);
  localparam logic [7:0] D_MAX  = 8'(DUTY_MAX);
  localparam logic [7:0] D_STEP = 8'(DUTY_STEP);

  fsm_e       fsm_q, fsm_d;
  logic [7:0] duty_q, duty_d;
  logic [1:0] timer_sel_q, timer_sel_d;
  logic [2:0] timer_left_q, timer_left_d;
  logic       shut_off_q, shut_off_d;
  logic       timeout_q;
  logic [1:0] sel_prev_q;
  logic       auto_prev_q;

  stage_e     sel;
  logic [7:0] target;
  logic [7:0] step_duty;
  logic       sel_changed;
  logic       tick_ms;
  logic       phase_wrap, phase_clr, phase_en;
  logic       unit_wrap, unit_en;
  logic       expire;
  logic [1:0] sel_base;

  assign sel         = stage_e'(auto_onoff ? stage_auto : stage_man);
  assign sel_changed = (sel != sel_prev_q) || (auto_onoff != auto_prev_q);

  always_comb begin
    target = '0;
    if (!shut_off_q) begin
      case (sel)
        STAGE_LOW:  target = D_LOW;
        STAGE_HIGH: target = D_HIGH;
        STAGE_MAX:  target = D_MAX;
        default:    target = '0;
      endcase
    end
  end

  fan_ms_divider #(.WIDTH(PRE_W)) u_prescale (
    .clk    (clk),
    .reset_p(reset_p),
    .en_i   (1'b1),
    .clr_i  (1'b0),
    .last_i (PRE_LAST),
    .wrap_o (tick_ms)
  );

  // One counter serves both kick and ramp timing; it is cleared on every
  // FSM transition so each phase starts counting from zero.
  assign phase_en  = tick_ms && ((fsm_q == FSM_KICK) || (fsm_q == FSM_RAMP));
  assign phase_clr = (fsm_d != fsm_q);

  fan_ms_divider #(.WIDTH(PH_W)) u_phase (
    .clk    (clk),
    .reset_p(reset_p),
    .en_i   (phase_en),
    .clr_i  (phase_clr),
    .last_i ((fsm_q == FSM_KICK) ? KICK_LAST : RAMP_LAST),
    .wrap_o (phase_wrap)
  );

  // Step toward target, clamped so the step never crosses it.
  always_comb begin
    step_duty = target;
    if (duty_q < target) begin
      if ((target - duty_q) > D_STEP) step_duty = duty_q + D_STEP;
    end else if (duty_q > target) begin
      if ((duty_q - target) > D_STEP) step_duty = duty_q - D_STEP;
    end
  end

  always_comb begin
    fsm_d  = fsm_q;
    duty_d = duty_q;
    case (fsm_q)
      FSM_IDLE: begin
        duty_d = '0;
        if (target != '0) begin
          fsm_d  = FSM_KICK;
          duty_d = D_MAX;
        end
      end
      FSM_KICK: begin
        if ((target == '0) || phase_wrap) fsm_d = FSM_RAMP;
      end
      FSM_RAMP: begin
        if (duty_q == target) begin
          fsm_d = (duty_q == '0) ? FSM_IDLE : FSM_HOLD;
        end else if (phase_wrap) begin
          duty_d = step_duty;
          if (step_duty == target) fsm_d = (step_duty == '0) ? FSM_IDLE : FSM_HOLD;
        end
      end
      FSM_HOLD: begin
        if (target != duty_q) fsm_d = FSM_RAMP;
      end
      default: fsm_d = FSM_IDLE;
    endcase
  end

  assign state   = (duty_q != '0) || (fsm_q == FSM_KICK);
  assign ramping = (fsm_q == FSM_KICK) || (fsm_q == FSM_RAMP);

  // Unit divider only advances while running; when stopped it holds its count.
  assign unit_en = tick_ms && state && (timer_sel_q != 2'd0);

  fan_ms_divider #(.WIDTH(UNIT_W)) u_unit (
    .clk    (clk),
    .reset_p(reset_p),
    .en_i   (unit_en),
    .clr_i  (timer_btn),
    .last_i (UNIT_LAST),
    .wrap_o (unit_wrap)
  );

  assign expire = unit_wrap && (timer_left_q == 3'd1);

  // Expiry is applied first, then a coincident button press advances from
  // the cleared selection and overrides the shut-off.
  always_comb begin
    timer_left_d = timer_left_q;
    shut_off_d   = shut_off_q;
    sel_base     = timer_sel_q;
    if (unit_wrap) timer_left_d = timer_left_q - 3'd1;
    if (expire) begin
      sel_base   = 2'd0;
      shut_off_d = 1'b1;
    end
    timer_sel_d = sel_base;
    if (timer_btn) begin
      timer_sel_d  = sel_base + 2'd1;
      timer_left_d = timer_units(sel_base + 2'd1);
    end
    if (timer_btn || sel_changed) shut_off_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      fsm_q        <= FSM_IDLE;
      duty_q       <= '0;
      timer_sel_q  <= '0;
      timer_left_q <= '0;
      shut_off_q   <= 1'b0;
      timeout_q    <= 1'b0;
      sel_prev_q   <= '0;
      auto_prev_q  <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      duty_q       <= duty_d;
      timer_sel_q  <= timer_sel_d;
      timer_left_q <= timer_left_d;
      shut_off_q   <= shut_off_d;
      timeout_q    <= expire;
      sel_prev_q   <= sel;
      auto_prev_q  <= auto_onoff;
    end
  end

  assign duty       = duty_q;
  assign timer_sel  = timer_sel_q;
  assign timer_left = timer_left_q;
  assign timeout    = timeout_q;

endmodule
